// File: rtl/sram_responder.sv
// Device-side model of the 32-bit asynchronous SRAM pin interface: byte-lane word
// array, optional read latency, access counters and a sticky bus-contention flag.

module sram_lane #(
  parameter int ADDR_W = 10
) (
  input  logic              clk50,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wd,
  output logic [7:0]        rd,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [7:0]        dbg_rd
);
  logic [7:0] mem [2**ADDR_W];

  // No reset on the array: contents survive rst_n pulses.
  always_ff @(posedge clk50)
    if (we) mem[addr] <= wd;

  assign rd     = mem[addr];
  assign dbg_rd = mem[dbg_addr];
endmodule

module sram_responder #(
  parameter int          ADDR_W      = 10,
  parameter int          READ_LAT    = 0,
  parameter logic [31:0] INVALID_PAT = 32'hDEAD_BEEF
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic [19:0]       ramAddr_i,
  input  logic              CE_n_i,
  input  logic              OE_n_i,
  input  logic              WE_n_i,
  input  logic [3:0]        be_n_i,
  inout  wire  [31:0]       data_io,
  output logic [15:0]       rd_cnt_o,
  output logic [15:0]       wr_cnt_o,
  output logic              contention_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [31:0]       dbg_data_o
);
  localparam int CW = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(READ_LAT);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_VALID, WR} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [ADDR_W-1:0] a, a_q;
  logic              wr_req, rd_req, addr_chg, rd_done, drive;
  logic [3:0]        we;
  logic [3:0][7:0]   rd_word, dbg_word, wr_word;
  logic [31:0]       rd_val;
  logic              unused_addr;

  assign a           = ramAddr_i[ADDR_W-1:0];
  assign unused_addr = ^ramAddr_i[19:ADDR_W];
  assign wr_req      = !CE_n_i && !WE_n_i;
  assign rd_req      = !CE_n_i && !OE_n_i && WE_n_i;
  assign addr_chg    = (a != a_q);
  assign wr_word     = data_io;
  assign we          = {4{wr_req && rst_n}} & ~be_n_i;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    sram_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk50    (clk50),
      .we       (we[k]),
      .addr     (a),
      .wd       (wr_word[k]),
      .rd       (rd_word[k]),
      .dbg_addr (dbg_addr_i),
      .dbg_rd   (dbg_word[k])
    );
  end

  assign dbg_data_o = dbg_word;

  // Reset gates the driver combinationally so the bus releases without waiting for an edge.
  assign drive   = rd_req && rst_n;
  assign rd_val  = (READ_LAT == 0 || state == RD_VALID) ? rd_word : INVALID_PAT;
  assign data_io = drive ? rd_val : 32'bz;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rd_done = 1'b0;
    if (CE_n_i) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (wr_req) begin
      state_n = WR;
      cnt_n   = '0;
      rd_done = (state == RD_VALID);
    end else if (rd_req) begin
      if (state == RD_WAIT && !addr_chg) begin
        cnt_n   = cnt + 1'b1;
        state_n = (cnt_n == LAT) ? RD_VALID : RD_WAIT;
      end else if (state == RD_VALID && (READ_LAT == 0 || !addr_chg)) begin
        state_n = RD_VALID;
      end else begin
        // New access or new address: the stable-request count starts over.
        cnt_n   = CW'(1);
        state_n = (READ_LAT <= 1) ? RD_VALID : RD_WAIT;
      end
    end else begin
      state_n = IDLE;
      cnt_n   = '0;
      rd_done = (state == RD_VALID);
    end
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      a_q          <= '0;
      rd_cnt_o     <= '0;
      wr_cnt_o     <= '0;
      contention_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      a_q   <= a;
      if (rd_done) rd_cnt_o <= rd_cnt_o + 16'd1;
      if (wr_req)  wr_cnt_o <= wr_cnt_o + 16'd1;
      if (!CE_n_i && !OE_n_i && !WE_n_i) contention_o <= 1'b1;
    end
  end
endmodule
